// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the CPU memory-port arbiter.
//   arb_state_e : arbiter FSM state (IDLE, BUSY, RESP)
//   arb_owner_e : which core port owns the current memory access
//   ADDR_W_DEF / DATA_W_DEF : default port widths
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_arb_starve_guard.sv
// Fetch starvation guard for mem_port_arbiter.
// Counts consecutive data grants made while a fetch was waiting and raises
// force_fetch_o once MAX_DATA_STREAK of them have happened in a row.
// Only instantiated when MEM_ARB_STARVE_GUARD_EN is defined.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   grant_i        : an arbitration decision is made this cycle
//   grant_data_i   : that decision went to the data port
//   if_req_i       : fetch port is requesting this cycle
//   force_fetch_o  : streak limit reached, next fetch must win
module mem_arb_starve_guard #(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic grant_i,
    input  logic grant_data_i,
    input  logic if_req_i,
    output logic force_fetch_o
);

    localparam int unsigned CNT_W = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);

    logic [CNT_W-1:0] streak_q;
    logic [CNT_W-1:0] streak_d;

    always_comb begin
        streak_d = streak_q;
        if (grant_i) begin
            if (!grant_data_i) begin
                streak_d = '0;
            end else if (if_req_i && (streak_q != CNT_W'(MAX_DATA_STREAK))) begin
                // Saturate: at the limit a waiting fetch always wins anyway.
                streak_d = streak_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign force_fetch_o = (streak_q == CNT_W'(MAX_DATA_STREAK));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between the instruction
// fetch port and the load/store data port of a stall-based core. Data has
// fixed priority (it belongs to the older instruction). Every access runs
// IDLE -> BUSY (until mem_ready) -> RESP (one-cycle done pulse) -> IDLE.
// All outputs are registered.
// Optional: define MEM_ARB_STARVE_GUARD_EN to let a waiting fetch win after
// MAX_DATA_STREAK consecutive data grants.
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   if_req/if_addr                    : fetch request (held until if_done)
//   if_done/if_rdata                  : fetch completion pulse and word
//   d_req/d_we/d_addr/d_wdata         : load/store request (held until d_done)
//   d_done/d_rdata                    : data completion pulse and load data
//   mem_req/mem_we/mem_addr/mem_wdata : memory access, stable until mem_ready
//   mem_rdata/mem_ready               : memory read data and completion
//   busy                              : arbiter not in IDLE
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W          = ADDR_W_DEF,
    parameter int unsigned DATA_W          = DATA_W_DEF,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    arb_state_e        state_q,     state_d;
    arb_owner_e        owner_q,     owner_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_done_q,   if_done_d;
    logic              d_done_q,    d_done_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
    logic              busy_q,      busy_d;
    logic              force_fetch;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic arb_grant;
    logic arb_grant_data;

    assign arb_grant      = (state_q == IDLE) && (if_req || d_req);
    assign arb_grant_data = (owner_d == DATA);

    mem_arb_starve_guard #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) u_starve_guard (
        .clk          (clk),
        .reset        (reset),
        .grant_i      (arb_grant),
        .grant_data_i (arb_grant_data),
        .if_req_i     (if_req),
        .force_fetch_o(force_fetch)
    );
`else
    assign force_fetch = 1'b0;
`endif

    // State register (plus all registered outputs).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= FETCH;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic and arbitration.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    state_d = BUSY;
                    // The guard only overrides data when a fetch is actually waiting.
                    owner_d = (d_req && !(force_fetch && if_req)) ? DATA : FETCH;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: outputs are computed from the upcoming state so that they
    // can be registered without adding a cycle of latency.
    always_comb begin
        mem_req_d   = (state_d == BUSY);
        busy_d      = (state_d != IDLE);
        if_done_d   = (state_d == RESP) && (owner_d == FETCH);
        d_done_d    = (state_d == RESP) && (owner_d == DATA);
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        if ((state_q == IDLE) && (state_d == BUSY)) begin
            if (owner_d == DATA) begin
                mem_we_d    = d_we;
                mem_addr_d  = d_addr;
                mem_wdata_d = d_wdata;
            end else begin
                mem_we_d    = 1'b0;
                mem_addr_d  = if_addr;
                mem_wdata_d = d_wdata;
            end
        end

        if ((state_q == BUSY) && mem_ready) begin
            if (owner_q == DATA) begin
                d_rdata_d = mem_rdata;
            end else begin
                if_rdata_d = mem_rdata;
            end
        end
    end

    assign if_done   = if_done_q;
    assign if_rdata  = if_rdata_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: randomized fetch/data requesters,
// a bench-side memory with random wait states, and a transaction-level
// reference (grant decisions, access windows, expected data from a shadow
// memory). Honours MEM_ARB_STARVE_GUARD_EN for the grant-order check.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
    bit exp_order [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
`else
    localparam bit GUARD_EN = 1'b0;
    bit exp_order [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    localparam int MAX_STREAK = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_done, d_req, d_we, d_done;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ready, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .MAX_DATA_STREAK(MAX_STREAK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_done  (if_done),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Bench memory (answers the DUT) and shadow memory (reference view).
    logic [31:0] mem_arr [0:127];
    logic [31:0] ref_mem [0:127];

    // Requester agents: mode 0 = manual, 1 = random issue, 2 = always request.
    int          fa_mode = 0, da_mode = 0;
    bit          fa_act = 0, fa_rel = 0, da_act = 0, da_rel = 0;
    logic [31:0] fa_addr = '0, da_addr = '0, da_wdata = '0;
    bit          da_we = 0;

    // Reference bookkeeping: grant cycle and memory-ready cycle of the
    // current access (-1 = none), plus what that access must present.
    int          cyc = 0;
    int          g_cyc = -1, r_cyc = -1, rst_chk = -1;
    bit          e_data = 0, e_we = 0;
    logic [31:0] e_addr = '0, e_wdata = '0, exp_if_rdata = '0;
    int          streak = 0;
    int          w_fixed = -1, w_left = 0;
    bit          glitch_en = 0, do_reset = 0;

    // Observations of the DUT.
    logic [31:0] obs_addr [$];
    int          obs_cyc [$];
    int          n_if_done = 0, n_d_done = 0, last_if_done = 0, last_d_done = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: check registered outputs, then drive this cycle's inputs
    // and advance the reference.
    task automatic step();
        bit active, done_now, rel_f, rel_d, force_f;
        @(posedge clk);
        #1;
        cyc++;
        active   = (g_cyc >= 0) && (cyc > g_cyc) && (r_cyc < 0 || cyc <= r_cyc);
        done_now = (g_cyc >= 0) && (r_cyc >= 0) && (cyc == r_cyc + 1);
        rel_f = 1'b0;
        rel_d = 1'b0;
        if (if_done === 1'b1) begin n_if_done++; last_if_done = cyc; end
        if (d_done === 1'b1) begin n_d_done++; last_d_done = cyc; end

        check_eq("mem_req", 64'(mem_req), 64'(active));
        check_eq("busy", 64'(busy), 64'(g_cyc >= 0));
        check_eq("if_done", 64'(if_done), 64'(done_now && !e_data));
        check_eq("d_done", 64'(d_done), 64'(done_now && e_data));
        if (cyc == rst_chk) begin
            check_eq("rst_mem_we", 64'(mem_we), 64'(0));
            check_eq("rst_mem_addr", 64'(mem_addr), 64'(0));
            check_eq("rst_mem_wdata", 64'(mem_wdata), 64'(0));
            check_eq("rst_d_rdata", 64'(d_rdata), 64'(0));
        end
        if (active) begin
            if (cyc == g_cyc + 1) begin
                obs_addr.push_back(mem_addr);
                obs_cyc.push_back(cyc);
            end
            check_eq("mem_addr", 64'(mem_addr), 64'(e_addr));
            check_eq("mem_we", 64'(mem_we), 64'(e_we));
            if (e_we) check_eq("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
        end
        if (done_now) begin
            if (!e_data) begin
                exp_if_rdata = ref_mem[e_addr[8:2]];
                rel_f = 1'b1;
            end else begin
                if (!e_we) check_eq("d_rdata", 64'(d_rdata), 64'(ref_mem[e_addr[8:2]]));
                else ref_mem[e_addr[8:2]] = e_wdata;
                rel_d = 1'b1;
            end
            g_cyc = -1;
            r_cyc = -1;
        end
        check_eq("if_rdata", 64'(if_rdata), 64'(exp_if_rdata));

        if (do_reset) begin
            do_reset = 1'b0;
            reset = 1'b1;
            if_req = 1'b0;
            d_req = 1'b0;
            mem_ready = 1'b0;
            fa_act = 1'b0; fa_rel = 1'b0;
            da_act = 1'b0; da_rel = 1'b0;
            g_cyc = -1; r_cyc = -1;
            streak = 0;
            exp_if_rdata = '0;
            rst_chk = cyc + 1;
            return;
        end
        reset = 1'b0;

        // Requesters hold everything through their done cycle, change after.
        if (fa_rel) begin fa_act = 1'b0; fa_rel = 1'b0; end
        if (da_rel) begin da_act = 1'b0; da_rel = 1'b0; end
        if (!fa_act && (fa_mode == 2 || (fa_mode == 1 && $urandom_range(0, 2) == 0))) begin
            fa_act  = 1'b1;
            fa_addr = 32'($urandom_range(0, 63)) << 2;
        end
        if (!da_act && (da_mode == 2 || (da_mode == 1 && $urandom_range(0, 2) == 0))) begin
            da_act   = 1'b1;
            da_addr  = 32'h100 + (32'($urandom_range(0, 63)) << 2);
            da_we    = 1'($urandom_range(0, 1));
            da_wdata = $urandom;
        end
        fa_rel  = rel_f;
        da_rel  = rel_d;
        if_req  = fa_act;
        if_addr = fa_act ? fa_addr : $urandom;
        d_req   = da_act;
        d_addr  = da_act ? da_addr : $urandom;
        d_we    = da_act ? da_we : 1'($urandom_range(0, 1));
        d_wdata = da_act ? da_wdata : $urandom;

        // Memory: random wait states; stray ready pulses outside an access.
        if (active) begin
            if (cyc == g_cyc + 1) w_left = (w_fixed >= 0) ? w_fixed : $urandom_range(0, 3);
            if (w_left == 0) begin
                mem_ready = 1'b1;
                mem_rdata = mem_arr[mem_addr[8:2]];
                if (mem_we) mem_arr[mem_addr[8:2]] = mem_wdata;
                r_cyc = cyc;
            end else begin
                w_left--;
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
        end else begin
            mem_ready = glitch_en && ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
        end

        // Arbitration: data wins unless the streak limit says a waiting fetch goes.
        if (g_cyc < 0 && !done_now && (fa_act || da_act)) begin
            force_f = GUARD_EN && (streak == MAX_STREAK) && fa_act;
            e_data  = da_act && !force_f;
            if (e_data) begin
                if (fa_act && streak < MAX_STREAK) streak++;
            end else begin
                streak = 0;
            end
            e_addr  = e_data ? da_addr : fa_addr;
            e_we    = e_data && da_we;
            e_wdata = da_wdata;
            g_cyc   = cyc;
            r_cyc   = -1;
        end
    endtask

    task automatic run_for_dones(input string tag, input int want_if, input int want_d, input int budget);
        int t_if, t_d;
        t_if = n_if_done;
        t_d  = n_d_done;
        for (int i = 0; i < budget && ((n_if_done - t_if) < want_if || (n_d_done - t_d) < want_d); i++) begin
            step();
        end
        check_eq({tag, "_if_cnt"}, 64'(n_if_done - t_if), 64'(want_if));
        check_eq({tag, "_d_cnt"}, 64'(n_d_done - t_d), 64'(want_d));
    endtask

    initial begin
        int n0;
        for (int i = 0; i < 128; i++) begin
            mem_arr[i] = $urandom;
            ref_mem[i] = mem_arr[i];
        end
        mem_arr[4] = 32'h8C220004;
        ref_mem[4] = 32'h8C220004;
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        rst_chk = 1;
        step();

        // Zero-wait fetch of 0x10.
        w_fixed = 0;
        fa_act = 1'b1; fa_addr = 32'h10;
        run_for_dones("fetch", 1, 0, 20);
        check_eq("fetch_addr", 64'(obs_addr[$]), 64'h10);
        check_eq("fetch_lat", 64'(last_if_done - obs_cyc[$]), 64'(1));
        check_eq("fetch_word", 64'(if_rdata), 64'h8C220004);
        step();

        // Store with three wait states.
        w_fixed = 3;
        da_act = 1'b1; da_addr = 32'h40; da_we = 1'b1; da_wdata = 32'hDEADBEEF;
        run_for_dones("store", 0, 1, 30);
        check_eq("store_lat", 64'(last_d_done - obs_cyc[$]), 64'(4));
        check_eq("store_mem", 64'(mem_arr[16]), 64'hDEADBEEF);
        step();

        // Simultaneous fetch and load: data first, fetch in the next IDLE.
        w_fixed = 0;
        fa_act = 1'b1; fa_addr = 32'h20;
        da_act = 1'b1; da_addr = 32'h80; da_we = 1'b0;
        run_for_dones("both", 1, 1, 30);
        check_eq("both_first", 64'(obs_addr[$-1]), 64'h80);
        check_eq("both_second", 64'(obs_addr[$]), 64'h20);
        check_eq("both_gap", 64'(obs_cyc[$] - last_d_done), 64'(2));
        step();

        // Stray mem_ready while idle.
        glitch_en = 1'b1;
        n0 = n_if_done + n_d_done;
        repeat (12) step();
        check_eq("idle_ready_done", 64'(n_if_done + n_d_done - n0), 64'(0));
        check_eq("idle_ready_busy", 64'(busy), 64'(0));
        glitch_en = 1'b0;

        // Reset in the middle of an access.
        w_fixed = 3;
        fa_act = 1'b1; fa_addr = 32'h30;
        for (int i = 0; i < 10 && mem_req !== 1'b1; i++) step();
        check_eq("rmb_req", 64'(mem_req), 64'(1));
        step();
        do_reset = 1'b1;
        step();
        step();
        check_eq("rmb_busy", 64'(busy), 64'(0));
        check_eq("rmb_if_rdata", 64'(if_rdata), 64'(0));
        fa_act = 1'b1; fa_addr = 32'h30;
        run_for_dones("after_rst", 1, 0, 20);
        check_eq("after_rst_word", 64'(if_rdata), 64'(ref_mem[12]));
        step();

        // Grant order with both ports requesting continuously.
        w_fixed = -1;
        fa_mode = 2; da_mode = 2;
        do_reset = 1'b1;
        step();
        obs_addr.delete();
        obs_cyc.delete();
        for (int i = 0; i < 200 && obs_addr.size() < 6; i++) step();
        check_eq("order_cnt", 64'(obs_addr.size() >= 6), 64'(1));
        for (int i = 0; i < 6 && i < obs_addr.size(); i++) begin
            check_eq($sformatf("order%0d", i), 64'(obs_addr[i][8]), 64'(exp_order[i]));
        end
        fa_mode = 0; da_mode = 0;
        for (int i = 0; i < 60 && (fa_act || da_act); i++) step();

        // Random traffic with stray ready pulses and occasional resets.
        fa_mode = 1; da_mode = 1;
        glitch_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset = 1'b1;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
